// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 writeback-stage register-file write arbiter.
package msrv32_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam logic [4:0]  X0           = 5'd0;

   typedef enum logic [1:0] {
      StIdle,
      StHeld,
      StForce
   } arb_state_e;

endpackage

// File: rtl/msrv32_wr_hold_buf.sv
// One-entry holding register for a multi-cycle write that lost arbitration.
module msrv32_wr_hold_buf
   import msrv32_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [4:0]      addr_i,
   input  logic [XLEN-1:0] data_i,
   output logic            valid_o,
   output logic [4:0]      addr_o,
   output logic [XLEN-1:0] data_o
);

   logic            valid_q;
   logic [4:0]      addr_q;
   logic [XLEN-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         addr_q  <= addr_i;
         data_q  <= data_i;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule

// File: rtl/msrv32_rf_wr_arbiter.sv
// Integer RF / CSR write-port arbiter between pipeline writeback and a late multi-cycle requester.
// Optional statistics counters enabled by defining MSRV32_RF_WR_ARB_STATS_EN.
module msrv32_rf_wr_arbiter
   import msrv32_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
   input  logic            ms_riscv32_mp_clk_in,
   input  logic            ms_riscv32_mp_rst_in,
   input  logic            flush_in,
   input  logic            rf_wr_en_reg_in,
   input  logic [4:0]      rd_addr_reg_in,
   input  logic [XLEN-1:0] wb_data_in,
   input  logic            csr_wr_en_reg_in,
   input  logic            mc_valid_in,
   input  logic [4:0]      mc_rd_addr_in,
   input  logic [XLEN-1:0] mc_data_in,
   output logic            mc_ready_out,
   output logic            wr_en_integer_file_out,
   output logic [4:0]      rd_addr_out,
   output logic [XLEN-1:0] rd_data_out,
   output logic            wr_en_csr_file_out,
   output logic            stall_out
`ifdef MSRV32_RF_WR_ARB_STATS_EN
   ,
   output logic [15:0]     forced_cnt_out,
   output logic [15:0]     dropped_cnt_out
`endif
);

   arb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;

   logic              pipe_wr, mc_acc, mc_live, same_rd;
   logic              grant_pipe, grant_mc, grant_buf;
   logic              buf_load, buf_clear, buf_valid;
   logic [4:0]        buf_addr;
   logic [XLEN-1:0]   buf_data;
   logic [4:0]        wr_addr;
   logic [XLEN-1:0]   wr_data;

   logic              wr_en_q, csr_en_q;
   logic [4:0]        rd_addr_q;
   logic [XLEN-1:0]   rd_data_q;

   assign stall_out    = (state_q == StForce);
   assign mc_ready_out = (state_q == StIdle) & ms_riscv32_mp_rst_in;

   assign pipe_wr  = rf_wr_en_reg_in & ~flush_in & (rd_addr_reg_in != X0) & ~stall_out;
   assign mc_acc   = mc_valid_in & mc_ready_out;
   assign mc_live  = mc_acc & (mc_rd_addr_in != X0);
   assign same_rd  = (rd_addr_reg_in == buf_addr);
   assign wait_inc = wait_cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      grant_pipe = 1'b0;
      grant_mc   = 1'b0;
      grant_buf  = 1'b0;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mc_live && !pipe_wr) begin
               grant_mc = 1'b1;
            end else if (mc_live) begin
               grant_pipe = 1'b1;
               buf_load   = 1'b1;
               state_d    = StHeld;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               grant_pipe = pipe_wr;
            end
         end
         StHeld: begin
            if (!pipe_wr) begin
               grant_buf  = buf_valid;
               buf_clear  = 1'b1;
               state_d    = StIdle;
               wait_cnt_d = '0;
            end else if (same_rd) begin
               // Pipeline result is younger: the buffered write is stale.
               grant_pipe = 1'b1;
               buf_clear  = 1'b1;
               state_d    = StIdle;
               wait_cnt_d = '0;
            end else begin
               grant_pipe = 1'b1;
               wait_cnt_d = wait_inc;
               if (wait_inc == WAIT_W'(MAX_WAIT)) begin
                  state_d = StForce;
               end
            end
         end
         StForce: begin
            grant_buf  = buf_valid;
            buf_clear  = 1'b1;
            state_d    = StIdle;
            wait_cnt_d = '0;
         end
         default: begin
            state_d    = StIdle;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      wr_addr = rd_addr_reg_in;
      wr_data = wb_data_in;
      if (grant_mc) begin
         wr_addr = mc_rd_addr_in;
         wr_data = mc_data_in;
      end else if (grant_buf) begin
         wr_addr = buf_addr;
         wr_data = buf_data;
      end
   end

   msrv32_wr_hold_buf #(
      .XLEN (XLEN)
   ) u_hold_buf (
      .clk_i   (ms_riscv32_mp_clk_in),
      .rst_ni  (ms_riscv32_mp_rst_in),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .addr_i  (mc_rd_addr_in),
      .data_i  (mc_data_in),
      .valid_o (buf_valid),
      .addr_o  (buf_addr),
      .data_o  (buf_data)
   );

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         csr_en_q   <= 1'b0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         wr_en_q    <= grant_pipe | grant_mc | grant_buf;
         csr_en_q   <= csr_wr_en_reg_in & ~flush_in & ~stall_out;
         // Address/data hold their last value when nothing is granted.
         if (grant_pipe | grant_mc | grant_buf) begin
            rd_addr_q <= wr_addr;
            rd_data_q <= wr_data;
         end
      end
   end

   assign wr_en_integer_file_out = wr_en_q;
   assign wr_en_csr_file_out     = csr_en_q;
   assign rd_addr_out            = rd_addr_q;
   assign rd_data_out            = rd_data_q;

`ifdef MSRV32_RF_WR_ARB_STATS_EN
   logic        force_entry, waw_drop;
   logic [15:0] forced_cnt_q, dropped_cnt_q;

   assign force_entry = (state_q == StHeld) & (state_d == StForce);
   assign waw_drop    = (state_q == StHeld) & pipe_wr & same_rd;

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         forced_cnt_q  <= '0;
         dropped_cnt_q <= '0;
      end else begin
         if (force_entry && forced_cnt_q != 16'hFFFF) begin
            forced_cnt_q <= forced_cnt_q + 16'd1;
         end
         if (waw_drop && dropped_cnt_q != 16'hFFFF) begin
            dropped_cnt_q <= dropped_cnt_q + 16'd1;
         end
      end
   end

   assign forced_cnt_out  = forced_cnt_q;
   assign dropped_cnt_out = dropped_cnt_q;
`endif

endmodule

// File: tb/tb_msrv32_rf_wr_arbiter.sv
// Self-checking bench for msrv32_rf_wr_arbiter: scoreboard of expected RF writes plus
// per-scenario inline checks.
module tb_msrv32_rf_wr_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        rf_wr_en;
   logic [4:0]  rd_addr;
   logic [31:0] wb_data;
   logic        csr_wr_en;
   logic        mc_valid;
   logic [4:0]  mc_rd;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        wr_en;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        csr_out;
   logic        stall;
`ifdef MSRV32_RF_WR_ARB_STATS_EN
   logic [15:0] forced_cnt;
   logic [15:0] dropped_cnt;
`endif

   int  n_checks = 0;
   int  n_pass   = 0;
   wr_t exp_q[$];

   msrv32_rf_wr_arbiter #(
      .XLEN     (32),
      .MAX_WAIT (8)
   ) dut (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_in   (rst),
      .flush_in               (flush),
      .rf_wr_en_reg_in        (rf_wr_en),
      .rd_addr_reg_in         (rd_addr),
      .wb_data_in             (wb_data),
      .csr_wr_en_reg_in       (csr_wr_en),
      .mc_valid_in            (mc_valid),
      .mc_rd_addr_in          (mc_rd),
      .mc_data_in             (mc_data),
      .mc_ready_out           (mc_ready),
      .wr_en_integer_file_out (wr_en),
      .rd_addr_out            (out_addr),
      .rd_data_out            (out_data),
      .wr_en_csr_file_out     (csr_out),
      .stall_out              (stall)
`ifdef MSRV32_RF_WR_ARB_STATS_EN
      ,
      .forced_cnt_out         (forced_cnt),
      .dropped_cnt_out        (dropped_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every observed RF write must match the oldest expected one.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got write rd=%0d data=%h, want no write", out_addr,
                     out_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (out_addr !== e.addr || out_data !== e.data)
               $display("FAIL sb_write: got rd=%0d data=%h, want rd=%0d data=%h", out_addr,
                        out_data, e.addr, e.data);
            else
               n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush     = 1'b0;
      rf_wr_en  = 1'b0;
      rd_addr   = 5'd0;
      wb_data   = 32'h0;
      csr_wr_en = 1'b0;
      mc_valid  = 1'b0;
      mc_rd     = 5'd0;
      mc_data   = 32'h0;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      flush     = 1'b0;
      rf_wr_en  = 1'b1;
      rd_addr   = 5'd5;
      wb_data   = 32'hFFFF_0000;
      csr_wr_en = 1'b1;
      mc_valid  = 1'b1;
      mc_rd     = 5'd7;
      mc_data   = 32'h1111_2222;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({wr_en, out_addr, out_data, csr_out, mc_ready, stall} !== 41'd0)
            $display("FAIL reset_outputs: got wr=%b a=%0d d=%h csr=%b rdy=%b st=%b, want all 0",
                     wr_en, out_addr, out_data, csr_out, mc_ready, stall);
         else
            n_pass++;
      end
      idle_inputs();
      rst = 1'b1;
      #1;
      n_checks++;
      if (mc_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", mc_ready);
      else n_pass++;
      tick();
   endtask

   task automatic test_pipe();
      rf_wr_en = 1'b1;
      rd_addr  = 5'd5;
      wb_data  = 32'hA5A5_0001;
      expect_wr(5'd5, 32'hA5A5_0001);
      tick();
      n_checks++;
      if (wr_en !== 1'b1) $display("FAIL pipe_write: got wr_en=%b want 1", wr_en);
      else n_pass++;
      flush   = 1'b1;
      wb_data = 32'h0BAD_0001;
      tick();
      n_checks++;
      if (wr_en !== 1'b0 || out_addr !== 5'd5 || out_data !== 32'hA5A5_0001)
         $display("FAIL pipe_flush: got wr=%b a=%0d d=%h, want wr=0 a=5 d=a5a50001", wr_en,
                  out_addr, out_data);
      else n_pass++;
      flush   = 1'b0;
      rd_addr = 5'd0;
      tick();
      n_checks++;
      if (wr_en !== 1'b0) $display("FAIL pipe_x0: got wr_en=%b want 0", wr_en);
      else n_pass++;
      rf_wr_en  = 1'b0;
      csr_wr_en = 1'b1;
      flush     = 1'b1;
      tick();
      n_checks++;
      if (csr_out !== 1'b0) $display("FAIL csr_flush: got %b want 0", csr_out);
      else n_pass++;
      flush = 1'b0;
      tick();
      n_checks++;
      if (csr_out !== 1'b1) $display("FAIL csr_write: got %b want 1", csr_out);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_bypass();
      mc_valid = 1'b1;
      mc_rd    = 5'd7;
      mc_data  = 32'h0000_1234;
      expect_wr(5'd7, 32'h0000_1234);
      tick();
      idle_inputs();
      n_checks++;
      if (wr_en !== 1'b1 || mc_ready !== 1'b1 || stall !== 1'b0)
         $display("FAIL mc_bypass: got wr=%b rdy=%b st=%b, want 1 1 0", wr_en, mc_ready, stall);
      else n_pass++;
      mc_valid = 1'b1;
      mc_rd    = 5'd0;
      mc_data  = 32'hDEAD_0000;
      tick();
      idle_inputs();
      n_checks++;
      if (wr_en !== 1'b0 || mc_ready !== 1'b1)
         $display("FAIL mc_x0_discard: got wr=%b rdy=%b, want 0 1", wr_en, mc_ready);
      else n_pass++;
      tick();
   endtask

   task automatic test_conflict();
      mc_valid = 1'b1;
      mc_rd    = 5'd7;
      mc_data  = 32'h7777_0007;
      rf_wr_en = 1'b1;
      rd_addr  = 5'd3;
      wb_data  = 32'h3333_0003;
      expect_wr(5'd3, 32'h3333_0003);
      expect_wr(5'd7, 32'h7777_0007);
      tick();
      idle_inputs();
      n_checks++;
      if (mc_ready !== 1'b0 || wr_en !== 1'b1)
         $display("FAIL conflict_held: got rdy=%b wr=%b, want 0 1", mc_ready, wr_en);
      else n_pass++;
      tick();
      n_checks++;
      if (mc_ready !== 1'b1 || wr_en !== 1'b1)
         $display("FAIL conflict_drain: got rdy=%b wr=%b, want 1 1", mc_ready, wr_en);
      else n_pass++;
      tick();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL conflict_pending: got %0d left want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_waw();
      mc_valid = 1'b1;
      mc_rd    = 5'd9;
      mc_data  = 32'hDEAD_0009;
      rf_wr_en = 1'b1;
      rd_addr  = 5'd2;
      wb_data  = 32'h2222_0002;
      expect_wr(5'd2, 32'h2222_0002);
      tick();
      idle_inputs();
      rf_wr_en = 1'b1;
      rd_addr  = 5'd9;
      wb_data  = 32'h0000_BEEF;
      expect_wr(5'd9, 32'h0000_BEEF);
      tick();
      idle_inputs();
      n_checks++;
      if (mc_ready !== 1'b1) $display("FAIL waw_idle: got rdy=%b want 1", mc_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (wr_en !== 1'b0) $display("FAIL waw_no_stale: got wr_en=%b want 0", wr_en);
      else n_pass++;
`ifdef MSRV32_RF_WR_ARB_STATS_EN
      n_checks++;
      if (dropped_cnt !== 16'd1) $display("FAIL waw_stat: got %0d want 1", dropped_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_flush_survives();
      mc_valid = 1'b1;
      mc_rd    = 5'd10;
      mc_data  = 32'hAAAA_000A;
      rf_wr_en = 1'b1;
      rd_addr  = 5'd2;
      wb_data  = 32'h2222_0012;
      expect_wr(5'd2, 32'h2222_0012);
      tick();
      idle_inputs();
      flush    = 1'b1;
      rf_wr_en = 1'b1;
      rd_addr  = 5'd10;
      wb_data  = 32'h0BAD_000A;
      expect_wr(5'd10, 32'hAAAA_000A);
      tick();
      idle_inputs();
      n_checks++;
      if (wr_en !== 1'b1 || mc_ready !== 1'b1)
         $display("FAIL flush_buf_survives: got wr=%b rdy=%b, want 1 1", wr_en, mc_ready);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_held();
      mc_valid = 1'b1;
      mc_rd    = 5'd12;
      mc_data  = 32'hCCCC_000C;
      rf_wr_en = 1'b1;
      rd_addr  = 5'd2;
      wb_data  = 32'h2222_0022;
      expect_wr(5'd2, 32'h2222_0022);
      tick();
      idle_inputs();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (wr_en !== 1'b0 || mc_ready !== 1'b1)
         $display("FAIL reset_discard_buf: got wr=%b rdy=%b, want 0 1", wr_en, mc_ready);
      else n_pass++;
   endtask

   task automatic test_starvation();
      for (int i = 1; i <= 8; i++) begin
         idle_inputs();
         if (i == 1) begin
            mc_valid = 1'b1;
            mc_rd    = 5'd4;
            mc_data  = 32'h4444_0004;
         end
         rf_wr_en = 1'b1;
         rd_addr  = 5'(i + 10);
         wb_data  = 32'h1000 + 32'(i);
         expect_wr(5'(i + 10), 32'h1000 + 32'(i));
         tick();
         n_checks++;
         if (stall !== (i == 8) || mc_ready !== 1'b0)
            $display("FAIL starve_grant%0d: got st=%b rdy=%b, want st=%b rdy=0", i, stall,
                     mc_ready, (i == 8));
         else n_pass++;
      end
      idle_inputs();
      rf_wr_en  = 1'b1;
      rd_addr   = 5'd19;
      wb_data   = 32'h0000_1009;
      csr_wr_en = 1'b1;
      expect_wr(5'd4, 32'h4444_0004);
      tick();
      n_checks++;
      if (stall !== 1'b0 || wr_en !== 1'b1 || csr_out !== 1'b0)
         $display("FAIL starve_force: got st=%b wr=%b csr=%b, want 0 1 0", stall, wr_en, csr_out);
      else n_pass++;
      expect_wr(5'd19, 32'h0000_1009);
      tick();
      idle_inputs();
      n_checks++;
      if (csr_out !== 1'b1 || wr_en !== 1'b1)
         $display("FAIL starve_resume: got csr=%b wr=%b, want 1 1", csr_out, wr_en);
      else n_pass++;
`ifdef MSRV32_RF_WR_ARB_STATS_EN
      n_checks++;
      if (forced_cnt !== 16'd1) $display("FAIL force_stat: got %0d want 1", forced_cnt);
      else n_pass++;
`endif
      tick();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_pipe();
      test_bypass();
      test_conflict();
      test_waw();
      test_flush_survives();
      test_starvation();
      test_reset_held();
      tick();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL final_pending: got %0d left want 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
